// File: rtl/mipi_rx_packet_ctrl_if.sv
// Bundle between the lane aligner, the packet controller and the downstream consumer.
// The master modport is the controller's side; slave is the aligner/consumer side.
interface mipi_rx_packet_ctrl_if #(
    parameter int unsigned LANES = 4
);
    logic [LANES*8-1:0] al_data;
    logic               al_valid;
    logic               al_error;
    logic               al_rst;
    logic               hdr_valid;
    logic [7:0]         hdr_di;
    logic [15:0]        hdr_wc;
    logic [7:0]         hdr_ecc;
    logic [LANES*8-1:0] pl_data;
    logic               pl_valid;
    logic [LANES-1:0]   pl_keep;
    logic               pl_last;
    logic               err_trunc;
    logic               err_align;
    logic               err_size;
    logic [7:0]         err_cnt;

    modport master (
        input  al_data, al_valid, al_error,
        output al_rst, hdr_valid, hdr_di, hdr_wc, hdr_ecc,
        output pl_data, pl_valid, pl_keep, pl_last,
        output err_trunc, err_align, err_size, err_cnt
    );

    modport slave (
        output al_data, al_valid, al_error,
        input  al_rst, hdr_valid, hdr_di, hdr_wc, hdr_ecc,
        input  pl_data, pl_valid, pl_keep, pl_last,
        input  err_trunc, err_align, err_size, err_cnt
    );
endinterface

// File: rtl/mipi_rx_packet_ctrl.sv
// MIPI RX packet controller: parses the one-word header, frames payload with last/keep,
// and pulses the aligner reset after every packet or fault so each burst realigns.
module mipi_rx_packet_ctrl #(
    parameter int unsigned LANES      = 4,
    parameter int unsigned RST_CYCLES = 2,
    parameter logic [15:0] MAX_WC     = 16'd8192
) (
    input logic                  clk,
    input logic                  rst,
    mipi_rx_packet_ctrl_if.master rx_io
);

    typedef enum logic [1:0] {StResync, StWaitHdr, StPayload} state_e;

    state_e             state_q, state_d;
    logic [3:0]         rst_cnt_q, rst_cnt_d;
    logic [14:0]        words_left_q, words_left_d;
    logic [LANES-1:0]   last_keep_q, last_keep_d;
    logic               al_rst_q, al_rst_d;
    logic               hdr_valid_q, hdr_valid_d;
    logic [7:0]         hdr_di_q, hdr_di_d;
    logic [15:0]        hdr_wc_q, hdr_wc_d;
    logic [7:0]         hdr_ecc_q, hdr_ecc_d;
    logic [LANES*8-1:0] pl_data_q, pl_data_d;
    logic               pl_valid_q, pl_valid_d;
    logic [LANES-1:0]   pl_keep_q, pl_keep_d;
    logic               pl_last_q, pl_last_d;
    logic               err_trunc_q, err_trunc_d;
    logic               err_align_q, err_align_d;
    logic               err_size_q, err_size_d;
    logic [7:0]         err_cnt_q, err_cnt_d;

    logic [7:0]       di_in;
    logic [15:0]      wc_in;
    logic [7:0]       ecc_in;
    logic [16:0]      wc_words;
    logic [1:0]       rem;
    logic [LANES-1:0] keep_calc;
    logic             long_pkt;
    logic             resync;

    assign di_in    = rx_io.al_data[7:0];
    assign wc_in    = rx_io.al_data[23:8];
    assign ecc_in   = rx_io.al_data[31:24];
    assign long_pkt = di_in[5:0] >= 6'h10;
    // Payload plus 2 CRC bytes, rounded up to whole words: (wc + 2 + 3) / 4.
    assign wc_words = {1'b0, wc_in} + 17'd5;
    assign rem      = wc_in[1:0] + 2'd2;

    always_comb begin
        keep_calc = '1;
        if (rem != 2'd0) keep_calc = LANES'((5'd1 << rem) - 5'd1);
    end

    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        words_left_d = words_left_q;
        last_keep_d  = last_keep_q;
        al_rst_d     = 1'b0;
        hdr_valid_d  = 1'b0;
        hdr_di_d     = hdr_di_q;
        hdr_wc_d     = hdr_wc_q;
        hdr_ecc_d    = hdr_ecc_q;
        pl_data_d    = pl_data_q;
        pl_valid_d   = 1'b0;
        pl_keep_d    = '0;
        pl_last_d    = 1'b0;
        err_trunc_d  = 1'b0;
        err_align_d  = 1'b0;
        err_size_d   = 1'b0;
        err_cnt_d    = err_cnt_q;
        resync       = 1'b0;

        unique case (state_q)
            StResync: begin
                if (rst_cnt_q == 4'd1) begin
                    state_d = StWaitHdr;
                end else begin
                    rst_cnt_d = rst_cnt_q - 4'd1;
                    al_rst_d  = 1'b1;
                end
            end
            StWaitHdr: begin
                if (rx_io.al_error) begin
                    err_align_d = 1'b1;
                    resync      = 1'b1;
                end else if (rx_io.al_valid) begin
                    if (long_pkt && (wc_in > MAX_WC)) begin
                        err_size_d = 1'b1;
                        resync     = 1'b1;
                    end else begin
                        hdr_valid_d = 1'b1;
                        hdr_di_d    = di_in;
                        hdr_wc_d    = wc_in;
                        hdr_ecc_d   = ecc_in;
                        if (long_pkt) begin
                            state_d      = StPayload;
                            words_left_d = wc_words[16:2];
                            last_keep_d  = keep_calc;
                        end else begin
                            resync = 1'b1;
                        end
                    end
                end
            end
            StPayload: begin
                if (rx_io.al_error) begin
                    err_align_d = 1'b1;
                    resync      = 1'b1;
                end else if (!rx_io.al_valid) begin
                    err_trunc_d = 1'b1;
                    resync      = 1'b1;
                end else begin
                    pl_valid_d   = 1'b1;
                    pl_data_d    = rx_io.al_data;
                    words_left_d = words_left_q - 15'd1;
                    if (words_left_q == 15'd1) begin
                        pl_last_d = 1'b1;
                        pl_keep_d = last_keep_q;
                        resync    = 1'b1;
                    end else begin
                        pl_keep_d = '1;
                    end
                end
            end
            default: resync = 1'b1;
        endcase

        if (resync) begin
            state_d   = StResync;
            rst_cnt_d = 4'(RST_CYCLES);
            al_rst_d  = 1'b1;
        end

        if ((err_align_d || err_size_d || err_trunc_d) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StResync;
            rst_cnt_q    <= 4'(RST_CYCLES);
            words_left_q <= '0;
            last_keep_q  <= '0;
            al_rst_q     <= 1'b1;
            hdr_valid_q  <= 1'b0;
            hdr_di_q     <= '0;
            hdr_wc_q     <= '0;
            hdr_ecc_q    <= '0;
            pl_data_q    <= '0;
            pl_valid_q   <= 1'b0;
            pl_keep_q    <= '0;
            pl_last_q    <= 1'b0;
            err_trunc_q  <= 1'b0;
            err_align_q  <= 1'b0;
            err_size_q   <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            words_left_q <= words_left_d;
            last_keep_q  <= last_keep_d;
            al_rst_q     <= al_rst_d;
            hdr_valid_q  <= hdr_valid_d;
            hdr_di_q     <= hdr_di_d;
            hdr_wc_q     <= hdr_wc_d;
            hdr_ecc_q    <= hdr_ecc_d;
            pl_data_q    <= pl_data_d;
            pl_valid_q   <= pl_valid_d;
            pl_keep_q    <= pl_keep_d;
            pl_last_q    <= pl_last_d;
            err_trunc_q  <= err_trunc_d;
            err_align_q  <= err_align_d;
            err_size_q   <= err_size_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign rx_io.al_rst    = al_rst_q;
    assign rx_io.hdr_valid = hdr_valid_q;
    assign rx_io.hdr_di    = hdr_di_q;
    assign rx_io.hdr_wc    = hdr_wc_q;
    assign rx_io.hdr_ecc   = hdr_ecc_q;
    assign rx_io.pl_data   = pl_data_q;
    assign rx_io.pl_valid  = pl_valid_q;
    assign rx_io.pl_keep   = pl_keep_q;
    assign rx_io.pl_last   = pl_last_q;
    assign rx_io.err_trunc = err_trunc_q;
    assign rx_io.err_align = err_align_q;
    assign rx_io.err_size  = err_size_q;
    assign rx_io.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_mipi_rx_packet_ctrl.sv
// Directed bench for mipi_rx_packet_ctrl: cycle-accurate vector table plus
// hand sequences for error-count saturation and reset mid-payload.
module tb_mipi_rx_packet_ctrl;

    typedef struct {
        string       name;
        logic        v;
        logic        e;
        logic [31:0] d;
        logic        rst_o;
        logic        hv;
        logic [7:0]  di;
        logic [15:0] wc;
        logic [7:0]  ecc;
        logic        pv;
        logic [31:0] pd;
        logic [3:0]  keep;
        logic        last;
        logic [2:0]  err;  // {align, size, trunc}
        logic [7:0]  cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    mipi_rx_packet_ctrl_if #(.LANES(4)) bus ();

    mipi_rx_packet_ctrl #(
        .LANES     (4),
        .RST_CYCLES(2),
        .MAX_WC    (16'd8192)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .rx_io(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic void add(string n, logic v, logic e, logic [31:0] d, logic r, logic hv,
                                logic [7:0] di, logic [15:0] wc, logic [7:0] ecc, logic pv,
                                logic [31:0] pd, logic [3:0] keep, logic last, logic [2:0] err,
                                logic [7:0] cnt);
        vec_t t;
        t.name = n; t.v = v; t.e = e; t.d = d; t.rst_o = r; t.hv = hv; t.di = di; t.wc = wc;
        t.ecc = ecc; t.pv = pv; t.pd = pd; t.keep = keep; t.last = last; t.err = err;
        t.cnt = cnt;
        vecs.push_back(t);
    endfunction

    function automatic void idle(string n, logic r, logic [7:0] cnt);
        add(n, 0, 0, 32'h0, r, 0, 8'h0, 16'h0, 8'h0, 0, 32'h0, 4'h0, 0, 3'b000, cnt);
    endfunction

    function automatic void hdr(string n, logic [31:0] d, logic r, logic [7:0] cnt);
        add(n, 1, 0, d, r, 1, d[7:0], d[23:8], d[31:24], 0, 32'h0, 4'h0, 0, 3'b000, cnt);
    endfunction

    function automatic void word(string n, logic [31:0] d, logic r, logic [3:0] keep,
                                 logic last, logic [7:0] cnt);
        add(n, 1, 0, d, r, 0, 8'h0, 16'h0, 8'h0, 1, d, keep, last, 3'b000, cnt);
    endfunction

    task automatic check_vec(int i, vec_t t);
        logic bad;
        logic [2:0] err_act;
        err_act = {bus.err_align, bus.err_size, bus.err_trunc};
        bad = (bus.al_rst !== t.rst_o) || (bus.hdr_valid !== t.hv) || (bus.pl_valid !== t.pv) ||
              (bus.pl_keep !== t.keep) || (bus.pl_last !== t.last) || (err_act !== t.err) ||
              (bus.err_cnt !== t.cnt);
        if (t.hv && ((bus.hdr_di !== t.di) || (bus.hdr_wc !== t.wc) || (bus.hdr_ecc !== t.ecc)))
            bad = 1'b1;
        if (t.pv && (bus.pl_data !== t.pd)) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display({"FAIL %s (vec %0d): got rst=%b hv=%b di=%h wc=%h ecc=%h pv=%b pd=%h ",
                      "keep=%b last=%b err=%b cnt=%0d; want rst=%b hv=%b di=%h wc=%h ecc=%h ",
                      "pv=%b pd=%h keep=%b last=%b err=%b cnt=%0d"},
                     t.name, i, bus.al_rst, bus.hdr_valid, bus.hdr_di, bus.hdr_wc, bus.hdr_ecc,
                     bus.pl_valid, bus.pl_data, bus.pl_keep, bus.pl_last, err_act, bus.err_cnt,
                     t.rst_o, t.hv, t.di, t.wc, t.ecc, t.pv, t.pd, t.keep, t.last, t.err, t.cnt);
        end
    endtask

    task automatic check_bit(string n, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", n, act, exp);
        end
    endtask

    task automatic check_quiet(string n, logic r);
        // Everything idle apart from al_rst; err_cnt must be zero after reset.
        logic bad;
        bad = (bus.al_rst !== r) || bus.hdr_valid || bus.pl_valid || bus.pl_last ||
              (bus.pl_keep != 4'h0) || bus.err_trunc || bus.err_align || bus.err_size ||
              (bus.err_cnt != 8'h0) || (bus.hdr_di != 8'h0) || (bus.hdr_wc != 16'h0) ||
              (bus.pl_data != 32'h0);
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s: got rst=%b hv=%b pv=%b last=%b keep=%b err=%b%b%b cnt=%0d want rst=%b rest 0",
                     n, bus.al_rst, bus.hdr_valid, bus.pl_valid, bus.pl_last, bus.pl_keep,
                     bus.err_align, bus.err_size, bus.err_trunc, bus.err_cnt, r);
        end
    endtask

    initial begin
        logic [7:0] exp_cnt;
        bit         stuck;
        bus.al_valid = 1'b0;
        bus.al_error = 1'b0;
        bus.al_data  = 32'h0;

        idle("post_rst_hold", 1, 0);
        idle("post_rst_release", 0, 0);
        hdr("short_hdr", 32'h2A000001, 1, 0);
        add("resync_ignores_input", 1, 0, 32'h1100062C, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
        idle("short_resync_end", 0, 0);
        hdr("long6_hdr", 32'h1100062C, 0, 0);
        word("long6_w0", 32'hA1A2A3A4, 0, 4'b1111, 0, 0);
        word("long6_last", 32'hB1B2B3B4, 1, 4'b1111, 1, 0);
        idle("long6_resync", 1, 0);
        idle("long6_resync_end", 0, 0);
        hdr("long5_hdr", 32'h2200052D, 0, 0);
        word("long5_w0", 32'hC0C1C2C3, 0, 4'b1111, 0, 0);
        word("long5_last", 32'hD0D1D2D3, 1, 4'b0111, 1, 0);
        idle("long5_resync", 1, 0);
        idle("long5_resync_end", 0, 0);
        hdr("wc0_hdr", 32'h3300002E, 0, 0);
        word("wc0_crc_only", 32'hE0E1E2E3, 1, 4'b0011, 1, 0);
        idle("wc0_resync", 1, 0);
        idle("wc0_resync_end", 0, 0);
        idle("wait_hdr_idle", 0, 0);
        add("size_4000", 1, 0, 32'h4440002C, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b010, 1);
        idle("size_resync", 1, 1);
        idle("size_resync_end", 0, 1);
        add("size_8193", 1, 0, 32'h5520012C, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b010, 2);
        idle("size2_resync", 1, 2);
        idle("size2_resync_end", 0, 2);
        hdr("short_big_wc_no_err", 32'h6640000F, 1, 2);
        idle("short2_resync", 1, 2);
        idle("short2_resync_end", 0, 2);
        hdr("trunc_hdr", 32'h7700102C, 0, 2);
        word("trunc_w0", 32'h01020304, 0, 4'b1111, 0, 2);
        word("trunc_w1", 32'h05060708, 0, 4'b1111, 0, 2);
        add("trunc_drop", 0, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 3);
        idle("trunc_resync", 1, 3);
        idle("trunc_resync_end", 0, 3);
        hdr("align_hdr", 32'h8800062C, 0, 3);
        add("align_payload", 1, 1, 32'hDEADBEEF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b100, 4);
        add("align_in_resync_ignored", 0, 1, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 4);
        idle("align_resync_end", 0, 4);
        add("align_over_hdr", 1, 1, 32'h99000001, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b100, 5);
        idle("align2_resync", 1, 5);
        idle("align2_resync_end", 0, 5);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset_state", 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst          = 1'b0;
            bus.al_valid = vecs[i].v;
            bus.al_error = vecs[i].e;
            bus.al_data  = vecs[i].d;
            @(posedge clk);
            #1;
            check_vec(i, vecs[i]);
        end

        // Saturation: one al_error per resync window, expected count modelled here.
        exp_cnt = 8'd5;
        stuck   = 1'b0;
        for (int k = 0; k < 300 && !stuck; k++) begin
            @(negedge clk);
            bus.al_valid = 1'b0;
            bus.al_error = 1'b1;
            @(posedge clk);
            #1;
            if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
            checks++;
            if (!bus.err_align || (bus.err_cnt !== exp_cnt)) begin
                errors++;
                $display("FAIL sat_err_%0d: got align=%b cnt=%0d want align=1 cnt=%0d",
                         k, bus.err_align, bus.err_cnt, exp_cnt);
            end
            @(negedge clk);
            bus.al_error = 1'b0;
            for (int w = 0; w < 8; w++) begin
                @(posedge clk);
                #1;
                if (!bus.al_rst) break;
            end
            if (bus.al_rst) begin
                stuck = 1'b1;
                checks++;
                errors++;
                $display("FAIL sat_resync_timeout: got al_rst=1 want 0 within 8 cycles");
            end
        end
        checks++;
        if (bus.err_cnt !== 8'd255) begin
            errors++;
            $display("FAIL err_cnt_saturate: got %0d want 255", bus.err_cnt);
        end

        // Reset asserted mid-payload
        @(negedge clk);
        bus.al_valid = 1'b1;
        bus.al_data  = 32'h7700102C;
        @(posedge clk);
        #1;
        check_bit("midrst_hdr_valid", bus.hdr_valid, 1'b1);
        @(negedge clk);
        bus.al_data = 32'h11111111;
        @(posedge clk);
        #1;
        check_bit("midrst_w0_valid", bus.pl_valid, 1'b1);
        @(negedge clk);
        rst         = 1'b1;
        bus.al_data = 32'h22222222;
        @(posedge clk);
        #1;
        check_quiet("midrst_outputs", 1'b1);
        @(negedge clk);
        rst         = 1'b0;
        bus.al_data = 32'h33333333;
        @(posedge clk);
        #1;
        check_quiet("midrst_release_hold", 1'b1);
        @(negedge clk);
        bus.al_valid = 1'b0;
        @(posedge clk);
        #1;
        check_quiet("midrst_release_end", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mipi_rx_packet_ctrl.md
Name: mipi_rx_packet_ctrl

Overview:
Packet-level controller that sequences the 4-lane MIPI RX lane aligner. It consumes the aligner's merged word stream and parses the one-word packet header. It tracks payload length, frames payload words with last/keep, and pulses the aligner reset (al_rst) between packets and after any fault so that every burst is realigned from scratch.

Parameters:
LANES, 4, lane count; header parsing is defined for 4 only, other values unsupported
RST_CYCLES, 2, cycles al_rst is held high per resync (1..15)
MAX_WC, 16'd8192, largest accepted long-packet word count in bytes

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
al_data  in  LANES*8  aligned word from aligner; byte i = lane i
al_valid  in  1  al_data valid
al_error  in  1  aligner alignment-failure pulse
al_rst  out  1  reset to aligner, active-high
hdr_valid  out  1  one-cycle pulse: header fields valid
hdr_di  out  8  data identifier (header byte 0)
hdr_wc  out  16  word count {byte2, byte1}
hdr_ecc  out  8  header byte 3, passed through unchecked
pl_data  out  LANES*8  payload word (payload bytes followed by 2 CRC bytes)
pl_valid  out  1  pl_data valid
pl_keep  out  LANES  byte enables, 4'b1111 except possibly on last word
pl_last  out  1  final word of packet
err_trunc  out  1  pulse: al_valid dropped mid-payload
err_align  out  1  pulse: al_error seen
err_size  out  1  pulse: hdr_wc > MAX_WC on a long packet
err_cnt  out  8  saturating error count (saturates at 255)

Behaviour:
- All outputs registered; each reacts 1 cycle after the input cycle that causes it.
- Reset: state=RESYNC, rst_cnt=RST_CYCLES, al_rst=1, all other outputs 0, err_cnt=0.
- RESYNC: al_rst=1; rst_cnt decrements each cycle; at rst_cnt==1 -> WAIT_HDR with al_rst=0 next cycle. al_rst is high exactly RST_CYCLES cycles. Inputs ignored.
- WAIT_HDR: on al_valid, latch hdr_di/hdr_wc/hdr_ecc and pulse hdr_valid.
  - Short packet (hdr_di[5:0] < 6'h10): -> RESYNC. No payload.
  - Long packet, wc > MAX_WC: no hdr_valid, err_size pulse -> RESYNC.
  - Otherwise: words_left = ceil((wc+2)/4) (17-bit arithmetic, no overflow); -> PAYLOAD.
- PAYLOAD: each al_valid word is forwarded with pl_valid=1 and decrements words_left.
  - On the word where words_left==1: pl_last=1. pl_keep = 4'b1111 if (wc+2)%4==0, else (1<<((wc+2)%4))-1. Then -> RESYNC.
  - al_valid low in PAYLOAD: err_trunc pulse; partial packet gets no pl_last; -> RESYNC.
- al_error in any state other than RESYNC has priority over al_valid in the same cycle: word dropped, err_align pulse, -> RESYNC.
- Only one err_* pulse per cycle. Priority: align > size > trunc. err_cnt increments once per error pulse.
- wc==0 long packet: 1 word, pl_keep=4'b0011 (CRC only), pl_last=1.
- rst mid-packet: immediate return to reset values; no pl_last emitted.

Test Plan:
- Short packet: header {ecc=8'h2A, wc=16'h0000, di=8'h01} -> hdr_valid 1 cycle with di=01; then al_rst high 2 cycles; no pl_valid.
- Long packet wc=6, di=8'h2C, 2 payload words -> 2 pl_valid; second has pl_last=1, pl_keep=4'b1111; then al_rst pulse of 2 cycles.
- Long packet wc=5 -> 2 words; last pl_keep=4'b0111. Long packet wc=0 -> 1 word, pl_keep=4'b0011.
- wc=16'h4000 with MAX_WC=8192 -> err_size pulse, no hdr_valid, err_cnt=1, resync.
- Long packet wc=16, al_valid low after 2 words -> err_trunc, no pl_last, err_cnt increments; al_error coincident with al_valid -> err_align only, word not forwarded.
- 300 al_error pulses -> err_cnt saturates at 255; rst asserted mid-PAYLOAD -> all outputs 0, al_rst=1 next cycle.
